// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, shared pattern constants and phase-timer state encodings
package traffic_pkg;
  localparam logic [1:0] LIGHT_R = 2'b00;
  localparam logic [1:0] LIGHT_Y = 2'b01;
  localparam logic [1:0] LIGHT_G = 2'b10;
  // patterns are {north, east, south, west}
  localparam logic [7:0] PAT_RESET = {LIGHT_Y, LIGHT_Y, LIGHT_Y, LIGHT_Y};
  localparam logic [7:0] PAT_NS_G  = {LIGHT_G, LIGHT_R, LIGHT_G, LIGHT_R};
  localparam logic [7:0] PAT_NS_Y  = {LIGHT_Y, LIGHT_R, LIGHT_Y, LIGHT_R};
  localparam logic [7:0] PAT_EW_G  = {LIGHT_R, LIGHT_G, LIGHT_R, LIGHT_G};
  localparam logic [7:0] PAT_EW_Y  = {LIGHT_R, LIGHT_Y, LIGHT_R, LIGHT_Y};
  localparam logic [7:0] PAT_N_G   = {LIGHT_G, LIGHT_R, LIGHT_R, LIGHT_R};
  localparam logic [7:0] PAT_N_Y   = {LIGHT_Y, LIGHT_R, LIGHT_R, LIGHT_R};
  localparam logic [7:0] PAT_E_G   = {LIGHT_R, LIGHT_G, LIGHT_R, LIGHT_R};
  localparam logic [7:0] PAT_E_Y   = {LIGHT_R, LIGHT_Y, LIGHT_R, LIGHT_R};
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_LOAD  = 3'b001,
    ST_COUNT = 3'b010,
    ST_HOLD  = 3'b011,
    ST_ADV   = 3'b100
  } tstate_e;
  function automatic logic has_yellow(input logic [7:0] p);
    return p[7:6] == LIGHT_Y || p[5:4] == LIGHT_Y || p[3:2] == LIGHT_Y || p[1:0] == LIGHT_Y;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts enabled clk cycles and pulses tick one cycle after each wrap
module tick_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int PW = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic          tick,
  output logic [PW-1:0] cnt
);
  logic wrap;
  assign wrap = en && cnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= clr || wrap ? '0 : en ? cnt + PW'(1) : cnt;
      tick <= wrap && !clr;
    end
endmodule

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: dwell timer issuing one advance strobe per light phase
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int LONG_TICKS  = 5,
  parameter int SHORT_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       short_phase,
  input  logic       hold,
  output logic       advance,
  output logic       sec_tick,
  output logic [3:0] remaining,
  output logic [2:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  if (TICK_DIV < 2 || LONG_TICKS < 1 || LONG_TICKS > 15 || SHORT_TICKS < 1 || SHORT_TICKS > 15) begin : g_bad_params
    $error("traffic_phase_timer: TICK_DIV must be >=2 and LONG_TICKS/SHORT_TICKS within 1..15");
  end
  tstate_e       state_q, state_d;
  logic [3:0]    rem_q, rem_d;
  logic          adv_q;
  logic          wrap;
  logic [PW-1:0] cnt;
  tick_prescaler #(.TICK_DIV(TICK_DIV), .PW(PW)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == ST_COUNT && enable),
    .clr  (state_q == ST_LOAD),
    .tick (sec_tick),
    .cnt  (cnt)
  );
  assign wrap = state_q == ST_COUNT && enable && cnt == PW'(TICK_DIV - 1);
  always_comb begin
    state_d = ST_IDLE;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE:  state_d = enable ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        state_d = ST_COUNT;
        rem_d   = short_phase ? 4'(SHORT_TICKS) : 4'(LONG_TICKS);
      end
      ST_COUNT: begin
        state_d = !wrap || rem_q != 4'd1 ? ST_COUNT : hold ? ST_HOLD : ST_ADV;
        rem_d   = wrap ? rem_q - 4'd1 : rem_q;
      end
      ST_HOLD:  state_d = hold || !enable ? ST_HOLD : ST_ADV;
      ST_ADV:   state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      adv_q   <= state_d == ST_ADV;
    end
  assign advance   = adv_q;
  assign remaining = rem_q;
  assign state     = state_q;
endmodule
